// File: rtl/key_event.sv
// Key gesture decoder: turns debounced key edges into short-click, double-click,
// long-press and auto-repeat pulses using a single shared 26-bit cycle counter.
module key_event #(
  parameter logic [25:0] LONG_CNT   = 26'd50_000_000,
  parameter logic [25:0] DCLICK_CNT = 26'd15_000_000,
  parameter logic [25:0] REPEAT_CNT = 26'd10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_flag,
  input  logic key_state,
  output logic short_pulse,
  output logic double_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic busy
);

  typedef enum logic [4:0] {
    IDLE   = 5'b00001,
    PRESS1 = 5'b00010,
    WAIT2  = 5'b00100,
    PRESS2 = 5'b01000,
    HOLD   = 5'b10000
  } state_t;

  state_t      state, state_nxt;
  logic [25:0] cnt, cnt_nxt;
  logic        short_nxt, double_nxt, long_nxt, repeat_nxt;
  logic        press_ev, rel_ev;

  assign press_ev = key_flag & ~key_state;
  assign rel_ev   = key_flag &  key_state;

  // Events that make no sense in the current state fall through untouched.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    short_nxt  = 1'b0;
    double_nxt = 1'b0;
    long_nxt   = 1'b0;
    repeat_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (press_ev) begin
          state_nxt = PRESS1;
          cnt_nxt   = '0;
        end
      end
      PRESS1: begin
        if (rel_ev) begin
          state_nxt = WAIT2;
          cnt_nxt   = '0;
        end else if (cnt == LONG_CNT - 26'd1) begin
          long_nxt  = 1'b1;
          state_nxt = HOLD;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 26'd1;
        end
      end
      WAIT2: begin
        if (press_ev) begin
          state_nxt = PRESS2;
          cnt_nxt   = '0;
        end else if (cnt == DCLICK_CNT - 26'd1) begin
          short_nxt = 1'b1;
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 26'd1;
        end
      end
      PRESS2: begin
        if (rel_ev) begin
          double_nxt = 1'b1;
          state_nxt  = IDLE;
          cnt_nxt    = '0;
        end
      end
      HOLD: begin
        if (rel_ev) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == REPEAT_CNT - 26'd1) begin
          repeat_nxt = 1'b1;
          cnt_nxt    = '0;
        end else begin
          cnt_nxt = cnt + 26'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // busy is taken from the next state so it lines up with the registered state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      short_pulse  <= 1'b0;
      double_pulse <= 1'b0;
      long_pulse   <= 1'b0;
      repeat_pulse <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      short_pulse  <= short_nxt;
      double_pulse <= double_nxt;
      long_pulse   <= long_nxt;
      repeat_pulse <= repeat_nxt;
      busy         <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_key_event.sv
// Self-checking bench for key_event: directed gesture scenarios plus random key
// traffic, all checked against a timestamp-based gesture model.
module tb_key_event;

  localparam int LONG_I = 20;
  localparam int DCL_I  = 10;
  localparam int REP_I  = 5;

  logic clk = 1'b0;
  logic rst;
  logic key_flag;
  logic key_state;
  logic short_pulse, double_pulse, long_pulse, repeat_pulse, busy;

  always #5 clk = ~clk;

  key_event #(
    .LONG_CNT  (26'd20),
    .DCLICK_CNT(26'd10),
    .REPEAT_CNT(26'd5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_flag    (key_flag),
    .key_state   (key_state),
    .short_pulse (short_pulse),
    .double_pulse(double_pulse),
    .long_pulse  (long_pulse),
    .repeat_pulse(repeat_pulse),
    .busy        (busy)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_short, n_double, n_long, n_repeat;

  // Gesture model: remembers when the key went down/up and derives pulses from elapsed time.
  bit m_active, m_down, m_second;
  int m_tev, m_long;
  logic [4:0] exp_o;

  task automatic model_step(input bit rn, input bit p, input bit r);
    bit es, ed, el, er;
    es = 0; ed = 0; el = 0; er = 0;
    if (!rn) begin
      m_active = 0;
    end else if (!m_active) begin
      if (p) begin
        m_active = 1; m_down = 1; m_second = 0; m_tev = cyc; m_long = -1;
      end
    end else if (m_long >= 0) begin
      if (r) m_active = 0;
      else if ((cyc - m_long) % REP_I == 0) er = 1;
    end else if (m_down && !m_second) begin
      if (r) begin
        m_down = 0; m_tev = cyc;
      end else if (cyc - m_tev == LONG_I) begin
        el = 1; m_long = cyc;
      end
    end else if (!m_down) begin
      if (p) begin
        m_down = 1; m_second = 1;
      end else if (cyc - m_tev == DCL_I) begin
        es = 1; m_active = 0;
      end
    end else if (r) begin
      ed = 1; m_active = 0;
    end
    exp_o = {es, ed, el, er, m_active};
  endtask

  task automatic cycle(input bit rn, input bit p, input bit r);
    rst       = rn;
    key_flag  = p | r;
    key_state = r;
    @(posedge clk);
    cyc++;
    model_step(rn, p, r);
    #1;
    key_flag = 1'b0;
    n_short  += int'(short_pulse);
    n_double += int'(double_pulse);
    n_long   += int'(long_pulse);
    n_repeat += int'(repeat_pulse);
  endtask

  task automatic clear_counts();
    n_short = 0; n_double = 0; n_long = 0; n_repeat = 0;
  endtask

  task automatic test_reset();
    clear_counts();
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, i == 1, i == 2);
      total++;
      if ({short_pulse, double_pulse, long_pulse, repeat_pulse, busy} !== 5'b0) begin
        bad++;
        $display("[TB] FAIL reset_outputs cyc=%0d got=%b want=00000", i,
                 {short_pulse, double_pulse, long_pulse, repeat_pulse, busy});
      end
    end
    // A release straight out of reset must be ignored.
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0, i == 0);
      total++;
      if ({short_pulse, double_pulse, long_pulse, repeat_pulse, busy} !== exp_o) begin
        bad++;
        $display("[TB] FAIL release_after_reset cyc=%0d got=%b want=%b", i,
                 {short_pulse, double_pulse, long_pulse, repeat_pulse, busy}, exp_o);
      end
    end
  endtask

  task automatic test_short();
    int t_short = -1;
    clear_counts();
    for (int i = 0; i < 30; i++) begin
      cycle(1'b1, i == 0, i == 5);
      total++;
      if ({short_pulse, double_pulse, long_pulse, repeat_pulse, busy} !== exp_o) begin
        bad++;
        $display("[TB] FAIL short_cycle i=%0d got=%b want=%b", i,
                 {short_pulse, double_pulse, long_pulse, repeat_pulse, busy}, exp_o);
      end
      if (short_pulse) t_short = i;
    end
    total++;
    if (n_short != 1 || t_short != 15 || n_double + n_long + n_repeat != 0) begin
      bad++;
      $display("[TB] FAIL short_summary got n=%0d at=%0d others=%0d want n=1 at=15 others=0",
               n_short, t_short, n_double + n_long + n_repeat);
    end
  endtask

  task automatic test_double();
    int t_double = -1;
    clear_counts();
    for (int i = 0; i < 30; i++) begin
      cycle(1'b1, i == 0 || i == 9, i == 5 || i == 12);
      total++;
      if ({short_pulse, double_pulse, long_pulse, repeat_pulse, busy} !== exp_o) begin
        bad++;
        $display("[TB] FAIL double_cycle i=%0d got=%b want=%b", i,
                 {short_pulse, double_pulse, long_pulse, repeat_pulse, busy}, exp_o);
      end
      if (double_pulse) t_double = i;
    end
    total++;
    if (n_double != 1 || t_double != 12 || n_short != 0) begin
      bad++;
      $display("[TB] FAIL double_summary got n=%0d at=%0d short=%0d want n=1 at=12 short=0",
               n_double, t_double, n_short);
    end
  endtask

  task automatic test_long_repeat();
    int t_long = -1;
    clear_counts();
    for (int i = 0; i < 55; i++) begin
      cycle(1'b1, i == 0, i == 40);
      total++;
      if ({short_pulse, double_pulse, long_pulse, repeat_pulse, busy} !== exp_o) begin
        bad++;
        $display("[TB] FAIL long_cycle i=%0d got=%b want=%b", i,
                 {short_pulse, double_pulse, long_pulse, repeat_pulse, busy}, exp_o);
      end
      if (long_pulse) t_long = i;
    end
    total++;
    if (n_long != 1 || t_long != 20 || n_repeat != 3 || n_short + n_double != 0 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL long_summary got long=%0d at=%0d rep=%0d other=%0d busy=%b want 1 20 3 0 0",
               n_long, t_long, n_repeat, n_short + n_double, busy);
    end
  endtask

  task automatic test_long_boundary();
    int t_short = -1;
    clear_counts();
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, i == 0, i == 20);
      total++;
      if ({short_pulse, double_pulse, long_pulse, repeat_pulse, busy} !== exp_o) begin
        bad++;
        $display("[TB] FAIL long_edge_cycle i=%0d got=%b want=%b", i,
                 {short_pulse, double_pulse, long_pulse, repeat_pulse, busy}, exp_o);
      end
      if (short_pulse) t_short = i;
    end
    total++;
    if (n_long != 0 || n_short != 1 || t_short != 30) begin
      bad++;
      $display("[TB] FAIL long_edge_summary got long=%0d short=%0d at=%0d want 0 1 30",
               n_long, n_short, t_short);
    end
  endtask

  task automatic test_dclick_boundary();
    int t_double = -1;
    clear_counts();
    for (int i = 0; i < 30; i++) begin
      cycle(1'b1, i == 0 || i == 15, i == 5 || i == 18);
      total++;
      if ({short_pulse, double_pulse, long_pulse, repeat_pulse, busy} !== exp_o) begin
        bad++;
        $display("[TB] FAIL dclick_edge_cycle i=%0d got=%b want=%b", i,
                 {short_pulse, double_pulse, long_pulse, repeat_pulse, busy}, exp_o);
      end
      if (double_pulse) t_double = i;
    end
    total++;
    if (n_short != 0 || n_double != 1 || t_double != 18) begin
      bad++;
      $display("[TB] FAIL dclick_edge_summary got short=%0d double=%0d at=%0d want 0 1 18",
               n_short, n_double, t_double);
    end
  endtask

  task automatic test_reset_in_hold();
    clear_counts();
    for (int i = 0; i < 26; i++) cycle(1'b1, i == 0, 1'b0);
    total++;
    if (n_long != 1 || busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL hold_reached got long=%0d busy=%b want 1 1", n_long, busy);
    end
    clear_counts();
    for (int i = 26; i < 40; i++) begin
      cycle(i != 26, 1'b0, i == 28);
      total++;
      if ({short_pulse, double_pulse, long_pulse, repeat_pulse, busy} !== exp_o) begin
        bad++;
        $display("[TB] FAIL hold_reset_cycle i=%0d got=%b want=%b", i,
                 {short_pulse, double_pulse, long_pulse, repeat_pulse, busy}, exp_o);
      end
    end
    total++;
    if (n_short + n_double + n_long + n_repeat != 0 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL hold_reset_summary got pulses=%0d busy=%b want 0 0",
               n_short + n_double + n_long + n_repeat, busy);
    end
  endtask

  task automatic test_back_to_back();
    clear_counts();
    for (int i = 0; i < 30; i++) begin
      cycle(1'b1, i == 0 || i == 13, i == 2 || i == 14);
      total++;
      if ({short_pulse, double_pulse, long_pulse, repeat_pulse, busy} !== exp_o) begin
        bad++;
        $display("[TB] FAIL b2b_cycle i=%0d got=%b want=%b", i,
                 {short_pulse, double_pulse, long_pulse, repeat_pulse, busy}, exp_o);
      end
    end
    total++;
    if (n_short != 2 || n_double != 0) begin
      bad++;
      $display("[TB] FAIL b2b_summary got short=%0d double=%0d want 2 0", n_short, n_double);
    end
  endtask

  task automatic test_random();
    int rate;
    int sel;
    bit p, r, rn;
    clear_counts();
    for (int seg = 0; seg < 15; seg++) begin
      sel  = int'($urandom_range(0, 2));
      rate = (sel == 0) ? 3 : (sel == 1) ? 12 : 40;
      for (int i = 0; i < 200; i++) begin
        rn = ($urandom_range(0, 299) != 0);
        p = 0; r = 0;
        if ($urandom_range(0, rate - 1) == 0) begin
          if ($urandom_range(0, 1) == 0) p = 1;
          else r = 1;
        end
        cycle(rn, p, r);
        total++;
        if ({short_pulse, double_pulse, long_pulse, repeat_pulse, busy} !== exp_o) begin
          bad++;
          $display("[TB] FAIL random_cycle seg=%0d i=%0d got=%b want=%b", seg, i,
                   {short_pulse, double_pulse, long_pulse, repeat_pulse, busy}, exp_o);
        end
        if (int'(short_pulse) + int'(double_pulse) + int'(long_pulse) + int'(repeat_pulse) > 1) begin
          bad++;
          $display("[TB] FAIL random_onehot seg=%0d i=%0d got=%b want at most one pulse", seg, i,
                   {short_pulse, double_pulse, long_pulse, repeat_pulse});
        end
        total++;
      end
    end
    $display("[TB] random traffic: short=%0d double=%0d long=%0d repeat=%0d",
             n_short, n_double, n_long, n_repeat);
  endtask

  initial begin
    rst = 1'b0; key_flag = 1'b0; key_state = 1'b1;
    m_active = 0; m_down = 0; m_second = 0; m_tev = 0; m_long = -1;
    exp_o = '0;
    test_reset();
    test_short();
    test_double();
    test_long_repeat();
    test_long_boundary();
    test_dclick_boundary();
    test_reset_in_hold();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/key_event.md
KEY_EVENT -- requirements
Module: key_event

Interface
REQ-001 The block SHALL have parameter LONG_CNT, default 26'd50_000_000, meaning press-hold cycles before a long press (1 s at 50 MHz).
REQ-002 The block SHALL have parameter DCLICK_CNT, default 26'd15_000_000, meaning the release-to-second-press window in cycles (300 ms).
REQ-003 The block SHALL have parameter REPEAT_CNT, default 26'd10_000_000, meaning the auto-repeat period in cycles while held after a long press (200 ms).
REQ-004 All three parameters SHALL be legal only in the range 2..2^26-1; the counter SHALL be 26 bits.
REQ-005 clk  input  1  single system clock, all logic on posedge.
REQ-006 rst  input  1  synchronous, active-low reset.
REQ-007 key_flag  input  1  one-cycle pulse from the debouncer on a debounced key edge.
REQ-008 key_state  input  1  debounced key level, valid when key_flag=1 (0 = pressed, 1 = released).
REQ-009 short_pulse  output  1  one-cycle pulse for a single short click.
REQ-010 double_pulse  output  1  one-cycle pulse for a double click.
REQ-011 long_pulse  output  1  one-cycle pulse when a hold reaches LONG_CNT.
REQ-012 repeat_pulse  output  1  one-cycle pulse every REPEAT_CNT cycles while held after long_pulse.
REQ-013 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-014 The block SHALL decode two events: press = key_flag&!key_state; release = key_flag&key_state.
REQ-015 The FSM SHALL be one-hot with the states IDLE, PRESS1, WAIT2, PRESS2 and HOLD.
REQ-016 In IDLE, a press SHALL move the FSM to PRESS1 and clear cnt; all other inputs SHALL be ignored.
REQ-017 In PRESS1, cnt SHALL increment each cycle.
REQ-018 In PRESS1, a release SHALL move the FSM to WAIT2 and clear cnt.
REQ-019 In PRESS1, when cnt==LONG_CNT-1 with no release in that cycle, the block SHALL assert long_pulse, move to HOLD and clear cnt.
REQ-020 In PRESS1, a release in the same cycle as cnt==LONG_CNT-1 SHALL take priority: the FSM goes to WAIT2 and no long_pulse is issued.
REQ-021 In WAIT2, cnt SHALL increment; a press SHALL move the FSM to PRESS2.
REQ-022 In WAIT2, when cnt==DCLICK_CNT-1 with no press, the block SHALL assert short_pulse and return to IDLE.
REQ-023 In WAIT2, a press coinciding with the timeout SHALL win and the FSM goes to PRESS2.
REQ-024 In PRESS2, a release SHALL assert double_pulse and return the FSM to IDLE; PRESS2 SHALL have no timeout.
REQ-025 In HOLD, cnt SHALL increment; at cnt==REPEAT_CNT-1 the block SHALL assert repeat_pulse and clear cnt.
REQ-026 In HOLD, a release SHALL return the FSM to IDLE with no pulse; a release on the repeat cycle SHALL suppress repeat_pulse.
REQ-027 Key events inconsistent with the current state (a press in PRESS1/PRESS2/HOLD, a release in IDLE/WAIT2) SHALL be ignored, with no state change and no cnt change.
REQ-028 All outputs SHALL be registered, and each pulse SHALL be high exactly one cycle, in the cycle after the triggering condition is sampled.
REQ-029 At most one pulse output SHALL be high in any cycle.
REQ-030 cnt SHALL never exceed the active limit minus 1, so no wrap-around is possible.

Reset
REQ-031 While rst=0 at a clock edge, the FSM SHALL go to IDLE, cnt SHALL be 0, and all pulse outputs and busy SHALL be 0.
REQ-032 Reset SHALL override any event in the same cycle; a reset mid-press SHALL discard the event with no pulse on exit from reset.
REQ-033 After reset, the first release seen SHALL be ignored because the FSM is in IDLE.

Verification (bench parameters LONG_CNT=20, DCLICK_CNT=10, REPEAT_CNT=5)
REQ-034 Press, release 5 cycles later, then no activity -> short_pulse exactly once, 10 cycles after the release cycle (+1 registered), with no other pulses.
REQ-035 Press, release after 5, press again 4 cycles later, release after 3 -> double_pulse once, one cycle after the second release, and no short_pulse.
REQ-036 Press held for 40 cycles, then release -> long_pulse at press+20(+1), repeat_pulse at +5, +10, +15 thereafter (3 pulses), then nothing after release.
REQ-037 Release on exactly cnt==19 in PRESS1 -> no long_pulse, FSM enters WAIT2, and short_pulse follows after the timeout.
REQ-038 Press in WAIT2 on exactly cnt==9 -> no short_pulse; the following release yields double_pulse.
REQ-039 Drive rst=0 for 1 cycle while in HOLD, then release -> no pulse, busy=0, and the release is ignored.
